// File: rtl/pattern_select_ctrl_if.sv
// Button inputs and selection outputs of the pattern select controller.
// master = button/stimulus side, slave = the controller itself.
interface pattern_select_ctrl_if;
    logic btn_next;
    logic btn_prev;
    logic in1;
    logic in0;
    logic clear_pulse;
    logic db_next;
    logic db_prev;

    modport master (
        output btn_next, btn_prev,
        input  in1, in0, clear_pulse, db_next, db_prev
    );

    modport slave (
        input  btn_next, btn_prev,
        output in1, in0, clear_pulse, db_next, db_prev
    );
endinterface

// File: rtl/pattern_select_ctrl.sv
// Debounced next/prev push-buttons step a wrapping 2-bit pattern selection, with a clear pulse per change.
// Define AUTO_CYCLE_EN to add a free-running auto-advance of the selection every AUTO_PERIOD cycles.
module pattern_select_ctrl #(
    parameter int unsigned DB_CYCLES   = 1_000_000,
    parameter logic [1:0]  SEL_RESET   = 2'd0,
    parameter int unsigned AUTO_PERIOD = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pattern_select_ctrl_if.slave bus
);

    localparam int unsigned NUM_BTN  = 2;
    localparam int unsigned BTN_NEXT = 0;
    localparam int unsigned BTN_PREV = 1;
    localparam int unsigned DB_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

    // Counter widths assume at least two cycles for both the debounce and auto periods.
    if (DB_CYCLES < 2 || AUTO_PERIOD < 2) begin : g_bad_param
        $error("pattern_select_ctrl: DB_CYCLES and AUTO_PERIOD must be at least 2");
    end

    logic [NUM_BTN-1:0]  w_raw;
    logic [NUM_BTN-1:0]  r_sync1;
    logic [NUM_BTN-1:0]  r_sync2;
    logic [NUM_BTN-1:0]  r_db;
    logic [NUM_BTN-1:0]  r_db_d;
    logic [NUM_BTN-1:0]  r_press;
    logic [DB_CNT_W-1:0] r_cnt [NUM_BTN];

    logic       w_step_up;
    logic       w_step_dn;
    logic       w_btn_evt;
    logic       w_auto_tick;
    logic [1:0] w_sel_nxt;
    logic       w_sel_chg;
    logic [1:0] r_sel;
    logic       r_clear;

    assign w_raw = {bus.btn_prev, bus.btn_next};

    // Two-flop synchroniser for the asynchronous buttons.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db <= '0;
            for (int b = 0; b < NUM_BTN; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BTN; b++) begin
                if (r_sync2[b] == r_db[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == DB_LAST) begin
                    r_db[b]  <= r_sync2[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + DB_CNT_W'(1);
                end
            end
        end
    end

    // Registered press events: rising edges of the debounced levels only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_d  <= '0;
            r_press <= '0;
        end else begin
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end

    // Simultaneous next and prev events cancel each other.
    assign w_step_up = r_press[BTN_NEXT] & ~r_press[BTN_PREV];
    assign w_step_dn = r_press[BTN_PREV] & ~r_press[BTN_NEXT];
    assign w_btn_evt = w_step_up | w_step_dn;

`ifdef AUTO_CYCLE_EN
    localparam int unsigned AUTO_CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AUTO_CNT_W-1:0] AUTO_LAST = AUTO_CNT_W'(AUTO_PERIOD - 1);

    logic [AUTO_CNT_W-1:0] r_auto_cnt;

    assign w_auto_tick = (r_auto_cnt == AUTO_LAST);

    // Auto-advance timer restarts on every accepted button step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_cnt <= '0;
        end else if (w_btn_evt || w_auto_tick) begin
            r_auto_cnt <= '0;
        end else begin
            r_auto_cnt <= r_auto_cnt + AUTO_CNT_W'(1);
        end
    end
`else
    assign w_auto_tick = 1'b0;
`endif

    // Next selection; a button step takes priority over an auto tick.
    always_comb begin
        w_sel_nxt = r_sel;
        w_sel_chg = 1'b0;
        if (w_step_up) begin
            w_sel_nxt = r_sel + 2'd1;
            w_sel_chg = 1'b1;
        end else if (w_step_dn) begin
            w_sel_nxt = r_sel - 2'd1;
            w_sel_chg = 1'b1;
        end else if (w_auto_tick) begin
            w_sel_nxt = r_sel + 2'd1;
            w_sel_chg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel   <= SEL_RESET;
            r_clear <= 1'b0;
        end else begin
            r_sel   <= w_sel_nxt;
            r_clear <= w_sel_chg;
        end
    end

    assign bus.in1         = r_sel[1];
    assign bus.in0         = r_sel[0];
    assign bus.clear_pulse = r_clear;
    assign bus.db_next     = r_db[BTN_NEXT];
    assign bus.db_prev     = r_db[BTN_PREV];

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// Self-checking bench for pattern_select_ctrl: per-cycle reference model, directed table and corner sequences.
module tb_pattern_select_ctrl;

    localparam int unsigned DB      = 4;
    localparam logic [1:0]  SEL_RST = 2'd2;
    localparam int unsigned AP      = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    pattern_select_ctrl_if bus ();

    pattern_select_ctrl #(
        .DB_CYCLES  (DB),
        .SEL_RESET  (SEL_RST),
        .AUTO_PERIOD(AP)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;

    // Reference model: raw sample history, window-based debounce, delayed press application.
    bit         m_q      [2][$];
    bit         m_rise_q [2][$];
    bit         m_db     [2];
    logic [1:0] m_sel;
    bit         m_clr;
    int         m_e;
    int         m_last;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_q[b].delete();
            m_rise_q[b].delete();
            for (int i = 0; i < DB + 2; i++) m_q[b].push_back(1'b0);
            for (int i = 0; i < 3; i++) m_rise_q[b].push_back(1'b0);
            m_db[b] = 1'b0;
        end
        m_sel  = SEL_RST;
        m_clr  = 1'b0;
        m_e    = 0;
        m_last = 0;
    endtask

    task automatic model_step();
        bit raw [2];
        bit all_diff;
        bit rise;
        bit n;
        bit p;
        raw[0] = bus.btn_next;
        raw[1] = bus.btn_prev;
        m_e++;
        for (int b = 0; b < 2; b++) begin
            m_q[b].push_back(raw[b]);
            void'(m_q[b].pop_front());
            // Level accepted when the samples taken 2..DB+1 edges ago all disagree with it.
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) begin
                if (m_q[b][i] == m_db[b]) all_diff = 1'b0;
            end
            rise = 1'b0;
            if (all_diff) begin
                m_db[b] = !m_db[b];
                rise    = m_db[b];
            end
            m_rise_q[b].push_back(rise);
            void'(m_rise_q[b].pop_front());
        end
        n     = m_rise_q[0][0];
        p     = m_rise_q[1][0];
        m_clr = 1'b0;
        if (n != p) begin
            m_sel  = n ? m_sel + 2'd1 : m_sel - 2'd1;
            m_clr  = 1'b1;
            m_last = m_e;
        end
`ifdef AUTO_CYCLE_EN
        else if (((m_e - m_last) % AP) == 0) begin
            m_sel = m_sel + 2'd1;
            m_clr = 1'b1;
        end
`endif
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("sel",         int'({bus.in1, bus.in0}), int'(m_sel));
            chk("clear_pulse", int'(bus.clear_pulse),    int'(m_clr));
            chk("db_next",     int'(bus.db_next),        int'(m_db[0]));
            chk("db_prev",     int'(bus.db_prev),        int'(m_db[1]));
            if (bus.clear_pulse) pulse_cnt++;
        end
    endtask

    typedef struct {
        logic       nxt;
        logic       prv;
        int         hold;
        logic [1:0] exp_sel;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int         first_k;
        bit         seen;
        logic [1:0] sel0;

        vecs[0]  = '{1'b1, 1'b0, 12, 2'd0, 1};
        vecs[1]  = '{1'b0, 1'b0, 10, 2'd0, 0};
        vecs[2]  = '{1'b1, 1'b0, 12, 2'd1, 1};
        vecs[3]  = '{1'b0, 1'b0, 10, 2'd1, 0};
        vecs[4]  = '{1'b1, 1'b0, 12, 2'd2, 1};
        vecs[5]  = '{1'b0, 1'b0, 10, 2'd2, 0};
        vecs[6]  = '{1'b1, 1'b0, 12, 2'd3, 1};
        vecs[7]  = '{1'b0, 1'b0, 10, 2'd3, 0};
        vecs[8]  = '{1'b1, 1'b0, 12, 2'd0, 1};
        vecs[9]  = '{1'b0, 1'b0, 10, 2'd0, 0};
        vecs[10] = '{1'b0, 1'b1, 12, 2'd3, 1};
        vecs[11] = '{1'b0, 1'b0, 10, 2'd3, 0};
        vecs[12] = '{1'b1, 1'b1, 12, 2'd3, 0};
        vecs[13] = '{1'b0, 1'b0, 10, 2'd3, 0};
        vecs[14] = '{1'b0, 1'b1, 12, 2'd2, 1};
        vecs[15] = '{1'b0, 1'b0, 10, 2'd2, 0};

        model_reset();
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;

        // Reset applied between clock edges must take effect immediately.
        #2 reset_n = 1'b0;
        #1;
        chk("reset_sel",   int'({bus.in1, bus.in0}), 2);
        chk("reset_clear", int'(bus.clear_pulse),    0);
        chk("reset_db",    int'({bus.db_next, bus.db_prev}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        tick_n(3);

        // Single clean press: latency DB+4 edges, one pulse, no repeat while held.
        bus.btn_next = 1'b1;
        pulse_cnt    = 0;
        first_k      = -1;
        for (int k = 1; k <= 20; k++) begin
            tick_n(1);
            if (bus.clear_pulse && first_k < 0) first_k = k;
        end
        chk("press_latency", first_k, DB + 4);
`ifndef AUTO_CYCLE_EN
        chk("press_pulses", pulse_cnt, 1);
        chk("press_sel", int'({bus.in1, bus.in0}), 3);
`endif
        bus.btn_next = 1'b0;
        tick_n(10);

`ifndef AUTO_CYCLE_EN
        // Wrap-around, prev and simultaneous-press table.
        for (int v = 0; v < 16; v++) begin
            bus.btn_next = vecs[v].nxt;
            bus.btn_prev = vecs[v].prv;
            pulse_cnt    = 0;
            tick_n(vecs[v].hold);
            chk($sformatf("vec%0d_sel", v), int'({bus.in1, bus.in0}), int'(vecs[v].exp_sel));
            chk($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
        end
`endif

        // Bouncing input: toggle every 2 cycles, then settle high.
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        tick_n(10);
        sel0      = m_sel;
        pulse_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            bus.btn_next = (i % 2 == 0);
            tick_n(2);
        end
        bus.btn_next = 1'b1;
        tick_n(20);
`ifndef AUTO_CYCLE_EN
        chk("bounce_pulses", pulse_cnt, 1);
        chk("bounce_sel", int'({bus.in1, bus.in0}), int'(sel0 + 2'd1));
`endif
        bus.btn_next = 1'b0;
        tick_n(10);

        // Reset during a clear pulse with the button still held.
        bus.btn_next = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick_n(1);
            if (bus.clear_pulse) seen = 1'b1;
        end
        chk("midpulse_seen", int'(seen), 1);
        reset_n = 1'b0;
        #1;
        chk("midreset_sel",   int'({bus.in1, bus.in0}), 2);
        chk("midreset_clear", int'(bus.clear_pulse),    0);
        chk("midreset_db",    int'(bus.db_next),        0);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        pulse_cnt = 0;
        tick_n(20);
        chk("held_after_reset_pulses", pulse_cnt, 1);
        chk("held_after_reset_sel", int'({bus.in1, bus.in0}), 3);
        bus.btn_next = 1'b0;
        tick_n(10);

`ifdef AUTO_CYCLE_EN
        // Idle auto-advance, then a press landing exactly on a tick cycle.
        pulse_cnt = 0;
        tick_n(64);
        chk("auto_idle_pulses", pulse_cnt, 4);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (((m_e + DB + 4 - m_last) % AP) == 0) seen = 1'b1;
            else tick_n(1);
        end
        chk("auto_align_found", int'(seen), 1);
        sel0         = m_sel;
        bus.btn_next = 1'b1;
        pulse_cnt    = 0;
        tick_n(DB + 4);
        chk("auto_collide_pulses", pulse_cnt, 1);
        chk("auto_collide_sel", int'({bus.in1, bus.in0}), int'(sel0 + 2'd1));
        pulse_cnt = 0;
        tick_n(AP - 1);
        chk("auto_restart_quiet", pulse_cnt, 0);
        tick_n(1);
        chk("auto_restart_tick", pulse_cnt, 1);
        bus.btn_next = 1'b0;
        tick_n(10);
`endif

        // Randomised button activity against the model.
        for (int i = 0; i < 200; i++) begin
            bus.btn_next = 1'($urandom_range(0, 1));
            bus.btn_prev = 1'($urandom_range(0, 1));
            tick_n(int'($urandom_range(1, 12)));
        end
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        tick_n(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pattern_select_ctrl.md
Name: pattern_select_ctrl

Overview:
Front-end controller that produces the 2-bit pattern selection (in1/in0) consumed by the 7-segment pattern display. It takes two raw, bouncing push-buttons (next/prev), then synchronises, debounces and edge-detects them. It maintains a wrapping selection register and emits a one-cycle clear pulse so the iteration counter restarts whenever the pattern changes.

Parameters:
DB_CYCLES, 1_000_000, consecutive stable clk cycles needed to accept a new button level (10 ms at 100 MHz); legal range 2..2^24-1
SEL_RESET, 2'd0, selection value loaded on reset (0=glider, 1=blinker, 2=beacon, 3=pattern_d)
AUTO_PERIOD, 100_000_000, clk cycles between automatic advances (only used with AUTO_CYCLE_EN)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
btn_next  input  1  raw push-button, active-high, asynchronous to clk
btn_prev  input  1  raw push-button, active-high, asynchronous to clk
in1  output  1  selection MSB, registered
in0  output  1  selection LSB, registered
clear_pulse  output  1  one-cycle pulse, high on the cycle the selection changes
db_next  output  1  debounced level of btn_next (debug/LED)
db_prev  output  1  debounced level of btn_prev (debug/LED)

Behaviour:
- Reset (reset_n low, takes effect immediately without a clock):
  - {in1,in0}=SEL_RESET; clear_pulse=0; db_next=db_prev=0.
  - Synchroniser flops and debounce counters are cleared to 0.
- Synchroniser: two flops per button. Nothing downstream uses the raw input.
- Debounce (independent per button), with counter width ceil(log2(DB_CYCLES)):
  - sync == db: counter cleared to 0.
  - sync != db: counter increments.
  - Counter reaches DB_CYCLES-1 while sync != db: db takes sync and the counter clears.
  - Any glitch shorter than DB_CYCLES cycles leaves db unchanged.
- Press event: a registered rising edge of db (db=1, db_d=0). Releases never generate events.
- Selection update, in the cycle after a press event:
  - next only: sel = sel+1 mod 4 (3 wraps to 0).
  - prev only: sel = sel-1 mod 4 (0 wraps to 3).
  - next and prev events in the same cycle: no change and no clear_pulse.
- clear_pulse: high for exactly the one cycle in which {in1,in0} takes its new value; otherwise low.
- Total latency from a clean raw 0→1 edge to the sel change and clear_pulse: exactly DB_CYCLES+4 clk rising edges. Breakdown: 2 sync, DB_CYCLES debounce, 1 edge register, 1 sel register.
- Holding a button does not repeat. A new press requires a debounced release, then a debounced press.
- Reset asserted mid-debounce or mid-pulse: all state is abandoned. After release the block behaves as from power-up; a button still held generates one press once debounced.

Optional Feature:
AUTO_CYCLE_EN
- Defined:
  - A free-running counter of width ceil(log2(AUTO_PERIOD)) advances sel by +1 (with wrap) every AUTO_PERIOD cycles, with clear_pulse.
  - Any accepted button event reloads the auto counter to 0.
  - A button event and an auto tick in the same cycle: the button wins and only one update occurs.
- Undefined: no auto counter is synthesised and the selection changes only on button events.

Test Plan:
1. Reset value: DB_CYCLES=4, SEL_RESET=2. Assert reset_n=0 mid-simulation with no clock edge → {in1,in0}=2'b10 and clear_pulse=0 immediately.
2. Single press: DB_CYCLES=4, sel=0. Raise btn_next cleanly and hold 20 cycles → sel=1 exactly 8 edges after the input change; clear_pulse high for 1 cycle; no further change while held.
3. Bounce rejection: btn_next toggles every 2 cycles for 30 cycles, then stays high → exactly one increment and one clear_pulse after the level settles.
4. Wrap-around: 4 clean next presses from sel=0 → sel sequence 1,2,3,0. Then 1 prev press → sel=3.
5. Simultaneous press: btn_next and btn_prev rise on the same cycle → sel unchanged, clear_pulse never asserted.
6. Auto-advance (AUTO_CYCLE_EN, AUTO_PERIOD=16): idle for 64 cycles → 4 advances spaced 16 cycles apart. A next press landing on a tick cycle → single increment, and the auto counter restarts.
